tqvp_sprite_compositor: RTL and testbench
=========================================

Name: tqvp_sprite_compositor

Overview:
- Parametrised successor to the fixed 8-object sprite engine on the TinyQV video peripheral.
- Stores N sprite attribute records and bitmaps behind the TinyQV peripheral bus.
- Selects up to LINE_SLOTS sprites per scanline in a per-line evaluation FSM that runs during hblank.
- Outputs a registered, per-sprite-coloured pixel (RGB222) that sits above the background generator in the final mux, plus collision/overflow status and a frame interrupt.

Parameters:
- NUM_SPRITES, 8, sprite count; legal range 1..12.
- SPR_W, 8, sprite width in pixels and bitmap row width in bits; legal range 1..16.
- SPR_H, 8, sprite height in rows; power of two, 1..16.
- LINE_SLOTS, 4, maximum sprites drawn on one scanline; legal range 1..NUM_SPRITES.
- COORD_W, 10, pixel coordinate width.
- V_LAST, 524, last line number of the frame (V_TOTAL-1).

Ports:
- clk  in  1  pixel/system clock
- reset  in  1  synchronous, active-high reset
- pix_x  in  COORD_W  current pixel column from video_controller
- pix_y  in  COORD_W  current line from video_controller
- visible  in  1  active-video flag
- hsync  in  1  horizontal sync, active-high after polarity normalisation
- vsync  in  1  vertical sync, active-high after polarity normalisation
- address  in  6  register byte address
- data_in  in  32  write data
- data_write_n  in  2  11 = none, 00 = 8-bit, 01 = 16-bit, 10 = 32-bit
- data_read_n  in  2  same encoding as data_write_n, for reads
- data_out  out  32  read data
- data_ready  out  1  read/write acknowledge
- sprite_pixel_on  out  1  opaque sprite pixel present
- sprite_rgb  out  6  RGB222 colour of the winning sprite
- user_interrupt  out  1  frame interrupt

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset state: all registers, slots, FSM and outputs go to 0; all sprites disabled. data_ready is the exception and is tied to 1.
- Register map, attributes: ATTR[i] at 0x00+4i, i < NUM_SPRITES.
  - Fields: [9:0] x, [19:10] y, [25:20] rgb, [26] enable.
  - Write width applies byte lanes from bit 0 upward.
  - Addresses of unimplemented sprites: reads return 0, writes are ignored.
- Register map, control and bitmap:
  - 0x30 BMP_PTR: [6:0] row index = sprite*SPR_H + row.
  - 0x34 BMP_DATA: write stores the low SPR_W bits at BMP_PTR, then BMP_PTR increments, wrapping at NUM_SPRITES*SPR_H to 0. Read returns the row at BMP_PTR with no increment.
  - 0x38 STATUS: [0] frame_pend, [1] collision, [2] overflow. Sticky; writing 1 to a bit clears it.
  - 0x3C CTRL: [0] irq_en.
- Reads: combinational, data_out valid in the same cycle; unused bits read 0.
- Bitmap bit order: bit SPR_W-1 is the leftmost pixel.
- Evaluation FSM, states IDLE -> CLEAR -> SCAN -> IDLE:
  - Trigger: rising edge of hsync, on every line including vblank.
  - CLEAR (1 cycle): invalidate all slots; latch target = (pix_y==V_LAST) ? 0 : pix_y+1.
  - SCAN (NUM_SPRITES cycles, index i = 0 upward): sprite i hits when enable=1 and (target - y) mod 2^COORD_W < SPR_H. On a hit, load the next free slot with x, rgb and the bitmap row for (target - y).
  - Slots full and another hit: set overflow; the remaining sprites are skipped.
  - Timing requirement: total FSM time of NUM_SPRITES+1 cycles must be less than the hblank length.
  - An hsync edge while in SCAN is ignored.
  - Register or bitmap writes to a sprite take effect at its next evaluation; a write in the same cycle that sprite is scanned is not seen.
- Pixel path, one register stage:
  - Per slot: dx = pix_x - slot_x (COORD_W bits, wrapping); opaque when dx < SPR_W and the selected row bit is set.
  - Winner is the lowest slot index, which is also the lowest sprite index.
  - Outputs registered: sprite_pixel_on = visible & any_opaque; sprite_rgb = winner rgb, or 0 when no pixel.
  - Latency: 1 clk from pix_x to output.
- Interrupt: rising edge of vsync sets frame_pend; user_interrupt = frame_pend & irq_en.
- Simultaneous set and write-1-clear of a status bit in the same cycle: set wins.
- Reset mid-SCAN: FSM returns to IDLE and slots are cleared; no partial sprite output follows.

Optional Feature:
- Macro: SPRITE_COLLISION_EN.
- Defined: collision bit is set when two or more slots are opaque on the same visible pixel.
- Undefined: no comparison logic is built; STATUS[1] reads 0 and ignores writes.

Test Plan:
- Attributes: sprite 0 at x=100, y=50, rgb=0x30, enable=1, bitmap rows 0xFF. At line 50, x=100..107: sprite_pixel_on=1 and sprite_rgb=0x30, one clk after pix_x; x=99 and x=108 give 0.
- Priority: sprites 2 (rgb=0x0C) and 5 (rgb=0x03) both placed at (200,10) -> output rgb is 0x0C; with SPRITE_COLLISION_EN, STATUS reads 0x2.
- Overflow: LINE_SLOTS=4, five sprites enabled on line 20 -> only sprites 0..3 drawn; STATUS[2]=1; writing 0x4 to STATUS clears it.
- Wrap: sprite with y=V_LAST evaluated for line 0 (target 0) -> not drawn; sprite with y=0 is drawn on line 0 (evaluated during line V_LAST).
- Bitmap pointer: BMP_PTR=63, then two BMP_DATA writes -> rows 63 and 0 written (NUM_SPRITES=8, SPR_H=8); readback matches.
- Interrupt: irq_en=1, vsync rise -> user_interrupt=1 on the next cycle; write-1-clear of STATUS[0] drops it. Reset asserted mid-SCAN -> all outputs 0 on the next cycle.

Source files
------------

// File: rtl/tqvp_sprite_compositor.sv
// tqvp_sprite_compositor: stores NUM_SPRITES attribute/bitmap records, picks up to LINE_SLOTS per line during hblank, draws RGB222 sprite pixels.
// Latency: 1 clk from pix_x to sprite_pixel_on/sprite_rgb; register reads are combinational, writes land on the next clk.
// Backpressure: none, data_ready is tied high. Optional collision detection is built only when SPRITE_COLLISION_EN is defined.
module tqvp_sprite_compositor #(
  parameter int NUM_SPRITES = 8,
  parameter int SPR_W       = 8,
  parameter int SPR_H       = 8,
  parameter int LINE_SLOTS  = 4,
  parameter int COORD_W     = 10,
  parameter int V_LAST      = 524
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [COORD_W-1:0] pix_x,
  input  logic [COORD_W-1:0] pix_y,
  input  logic               visible,
  input  logic               hsync,
  input  logic               vsync,
  input  logic [5:0]         address,
  input  logic [31:0]        data_in,
  input  logic [1:0]         data_write_n,
  input  logic [1:0]         data_read_n,
  output logic [31:0]        data_out,
  output logic               data_ready,
  output logic               sprite_pixel_on,
  output logic [5:0]         sprite_rgb,
  output logic               user_interrupt
);
  localparam int DEPTH  = NUM_SPRITES * SPR_H;
  localparam int BI_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PTR_W  = (BI_W > 7) ? BI_W : 7;
  localparam int IDX_W  = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
  localparam int SLOT_W = $clog2(LINE_SLOTS + 1);
  localparam int ROW_W  = (SPR_H > 1) ? $clog2(SPR_H) : 1;

  typedef enum logic [1:0] {IDLE, CLEAR, SCAN} state_t;

  // register file
  logic [26:0]        attr [NUM_SPRITES];
  logic [SPR_W-1:0]   bmp  [DEPTH];
  logic [PTR_W-1:0]   bmp_ptr;
  logic               frame_pend, overflow, irq_en;
  logic               coll_bit;

  // evaluation state
  state_t             state, state_nxt;
  logic               hsync_q, vsync_q;
  logic [COORD_W-1:0] target;
  logic [IDX_W-1:0]   scan_idx;
  logic [SLOT_W-1:0]  slot_cnt;
  logic               slot_vld [LINE_SLOTS];
  logic [COORD_W-1:0] slot_x   [LINE_SLOTS];
  logic [5:0]         slot_rgb [LINE_SLOTS];
  logic [SPR_W-1:0]   slot_row [LINE_SLOTS];

  // bus decode
  logic        wr_en, st_wr;
  logic [3:0]  word;
  logic [31:0] wmask, wdat;
  logic [BI_W-1:0] ptr_idx;
  logic        ptr_ok;
  logic        unused_ok;

  assign data_ready = 1'b1;
  assign word       = address[5:2];
  assign wr_en      = (data_write_n != 2'b11);
  assign wdat       = data_in & wmask;
  assign st_wr      = wr_en && (word == 4'd14);
  assign ptr_idx    = bmp_ptr[BI_W-1:0];
  assign ptr_ok     = (bmp_ptr < PTR_W'(DEPTH));
  assign user_interrupt = frame_pend & irq_en;
  assign unused_ok  = &{1'b0, address[1:0], wdat[31:27], wmask[31:27]};

  // byte-lane mask grows from bit 0 with the access width
  always_comb begin
    case (data_write_n)
      2'b00:   wmask = 32'h0000_00FF;
      2'b01:   wmask = 32'h0000_FFFF;
      default: wmask = 32'hFFFF_FFFF;
    endcase
  end

  // scan-side lookup of the sprite currently being evaluated
  logic [COORD_W-1:0] dy;
  logic [BI_W-1:0]    scan_bmp_idx;
  logic               hit, slots_full, do_clear, do_scan, ovf_set;
  always_comb begin
    dy           = target - COORD_W'(attr[scan_idx][19:10]);
    hit          = attr[scan_idx][26] && (dy < COORD_W'(SPR_H));
    scan_bmp_idx = BI_W'(scan_idx) * BI_W'(SPR_H) + BI_W'(dy[ROW_W-1:0]);
    slots_full   = (slot_cnt == SLOT_W'(LINE_SLOTS));
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // FSM next state: hsync rise starts an evaluation, extra edges during CLEAR/SCAN are dropped
  always_comb begin
    state_nxt = state;
    do_clear  = 1'b0;
    do_scan   = 1'b0;
    ovf_set   = 1'b0;
    case (state)
      IDLE:  if (hsync && !hsync_q) state_nxt = CLEAR;
      CLEAR: begin
        do_clear  = 1'b1;
        state_nxt = SCAN;
      end
      SCAN: begin
        do_scan = 1'b1;
        if (hit && slots_full) begin
          ovf_set   = 1'b1;
          state_nxt = IDLE;
        end else if (scan_idx == IDX_W'(NUM_SPRITES - 1)) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // slot loading and target line latch
  always_ff @(posedge clk) begin
    if (reset) begin
      hsync_q  <= 1'b0;
      target   <= '0;
      scan_idx <= '0;
      slot_cnt <= '0;
      for (int s = 0; s < LINE_SLOTS; s++) begin
        slot_vld[s] <= 1'b0;
        slot_x[s]   <= '0;
        slot_rgb[s] <= '0;
        slot_row[s] <= '0;
      end
    end else begin
      hsync_q <= hsync;
      if (do_clear) begin
        target   <= (pix_y == COORD_W'(V_LAST)) ? '0 : pix_y + 1'b1;
        scan_idx <= '0;
        slot_cnt <= '0;
        for (int s = 0; s < LINE_SLOTS; s++) slot_vld[s] <= 1'b0;
      end
      if (do_scan) begin
        scan_idx <= scan_idx + 1'b1;
        if (hit && !slots_full) begin
          slot_cnt <= slot_cnt + 1'b1;
          for (int s = 0; s < LINE_SLOTS; s++) begin
            if (slot_cnt == SLOT_W'(s)) begin
              slot_vld[s] <= 1'b1;
              slot_x[s]   <= COORD_W'(attr[scan_idx][9:0]);
              slot_rgb[s] <= attr[scan_idx][25:20];
              slot_row[s] <= bmp[scan_bmp_idx];
            end
          end
        end
      end
    end
  end

  // per-slot opacity; lowest slot (= lowest sprite index) wins
  logic [COORD_W-1:0] dx;
  logic [SPR_W-1:0]   row_sh;
  logic               any_opq, multi_opq;
  logic [5:0]         win_rgb;
  always_comb begin
    any_opq   = 1'b0;
    multi_opq = 1'b0;
    win_rgb   = '0;
    dx        = '0;
    row_sh    = '0;
    for (int s = LINE_SLOTS - 1; s >= 0; s--) begin
      dx     = pix_x - slot_x[s];
      row_sh = slot_row[s] << dx;
      if (slot_vld[s] && (dx < COORD_W'(SPR_W)) && row_sh[SPR_W-1]) begin
        if (any_opq) multi_opq = 1'b1;
        any_opq = 1'b1;
        win_rgb = slot_rgb[s];
      end
    end
  end

  // registered pixel output stage
  always_ff @(posedge clk) begin
    if (reset) begin
      sprite_pixel_on <= 1'b0;
      sprite_rgb      <= '0;
    end else begin
      sprite_pixel_on <= visible & any_opq;
      sprite_rgb      <= (visible & any_opq) ? win_rgb : 6'd0;
    end
  end

`ifdef SPRITE_COLLISION_EN
  logic collision;
  assign coll_bit = collision;
  // sticky collision flag, a new collision beats a same-cycle clear
  always_ff @(posedge clk) begin
    if (reset) collision <= 1'b0;
    else       collision <= (visible & multi_opq) | (collision & ~(st_wr & wdat[1]));
  end
`else
  logic unused_coll;
  assign coll_bit    = 1'b0;
  assign unused_coll = multi_opq;
`endif

  // bus writes, bitmap pointer and sticky status
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_SPRITES; i++) attr[i] <= '0;
      for (int r = 0; r < DEPTH; r++) bmp[r] <= '0;
      bmp_ptr    <= '0;
      irq_en     <= 1'b0;
      frame_pend <= 1'b0;
      overflow   <= 1'b0;
      vsync_q    <= 1'b0;
    end else begin
      vsync_q    <= vsync;
      frame_pend <= (vsync & ~vsync_q) | (frame_pend & ~(st_wr & wdat[0]));
      overflow   <= ovf_set | (overflow & ~(st_wr & wdat[2]));
      if (wr_en) begin
        for (int i = 0; i < NUM_SPRITES; i++)
          if (word == 4'(i)) attr[i] <= (attr[i] & ~wmask[26:0]) | wdat[26:0];
        if (word == 4'd12) bmp_ptr <= wdat[PTR_W-1:0];
        if (word == 4'd13) begin
          if (ptr_ok) bmp[ptr_idx] <= wdat[SPR_W-1:0];
          bmp_ptr <= (bmp_ptr >= PTR_W'(DEPTH - 1)) ? '0 : bmp_ptr + 1'b1;
        end
        if (word == 4'd15) irq_en <= wdat[0];
      end
    end
  end

  // combinational read mux, unimplemented bits and addresses read 0
  always_comb begin
    data_out = '0;
    if (data_read_n != 2'b11) begin
      for (int i = 0; i < NUM_SPRITES; i++)
        if (word == 4'(i)) data_out = {5'b0, attr[i]};
      case (word)
        4'd12:   data_out[PTR_W-1:0] = bmp_ptr;
        4'd13:   if (ptr_ok) data_out[SPR_W-1:0] = bmp[ptr_idx];
        4'd14:   data_out[2:0] = {overflow, coll_bit, frame_pend};
        4'd15:   data_out[0] = irq_en;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tqvp_sprite_compositor.sv
// Testbench for tqvp_sprite_compositor: register table, directed scanline scenarios, randomized lines vs a reference model.
// Reference model selects sprites per line and resolves pixels from the attribute/bitmap arrays directly.
// Runs to completion on fixed cycle counts and prints a single summary line.
`timescale 1ns/1ps
module tb_tqvp_sprite_compositor;
  localparam int NS = 8, SW = 8, SH = 8, LS = 4, VL = 524;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  pix_x = '0, pix_y = '0;
  logic        visible = 1'b0, hsync = 1'b0, vsync = 1'b0;
  logic [5:0]  address = '0;
  logic [31:0] data_in = '0;
  logic [1:0]  data_write_n = 2'b11, data_read_n = 2'b11;
  logic [31:0] data_out;
  logic        data_ready, sprite_pixel_on, user_interrupt;
  logic [5:0]  sprite_rgb;

  always #5 clk = ~clk;

  tqvp_sprite_compositor dut (
    .clk(clk), .reset(reset), .pix_x(pix_x), .pix_y(pix_y), .visible(visible),
    .hsync(hsync), .vsync(vsync), .address(address), .data_in(data_in),
    .data_write_n(data_write_n), .data_read_n(data_read_n), .data_out(data_out),
    .data_ready(data_ready), .sprite_pixel_on(sprite_pixel_on), .sprite_rgb(sprite_rgb),
    .user_interrupt(user_interrupt)
  );

  int checks = 0, errors = 0;

  // reference model state
  logic [26:0] m_attr [NS];
  logic [7:0]  m_bmp  [NS*SH];
  int          sel_spr [LS];
  logic [7:0]  sel_row [LS];
  int          sel_n = 0;
  bit          m_ovf = 0, m_coll = 0, m_fp = 0;

  typedef struct {
    logic [5:0]  addr;
    logic [1:0]  wn;
    logic [31:0] wdat;
    logic [31:0] rexp;
  } vec_t;
  vec_t vt [12];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic bus_write(input logic [5:0] a, input logic [31:0] d, input logic [1:0] wn);
    address = a; data_in = d; data_write_n = wn;
    tick();
    data_write_n = 2'b11;
  endtask

  task automatic rd(input logic [5:0] a, output logic [31:0] d);
    address = a; data_read_n = 2'b10;
    #1 d = data_out;
    data_read_n = 2'b11;
  endtask

  task automatic model_clear();
    for (int i = 0; i < NS; i++) m_attr[i] = '0;
    for (int r = 0; r < NS*SH; r++) m_bmp[r] = '0;
    sel_n = 0; m_ovf = 0; m_coll = 0; m_fp = 0;
  endtask

  task automatic set_sprite(input int i, input int x, input int y, input int rgb, input bit en);
    logic [26:0] a;
    a = {en, 6'(rgb), 10'(y), 10'(x)};
    bus_write(6'(4*i), {5'b0, a}, 2'b10);
    m_attr[i] = a;
  endtask

  task automatic fill_rows(input int spr, input logic [7:0] v);
    bus_write(6'h30, 32'(spr*SH), 2'b10);
    for (int r = 0; r < SH; r++) begin
      bus_write(6'h34, {24'b0, v}, 2'b00);
      m_bmp[spr*SH + r] = v;
    end
  endtask

  task automatic disable_all();
    for (int i = 0; i < NS; i++) set_sprite(i, 0, 0, 0, 1'b0);
  endtask

  task automatic clear_status();
    bus_write(6'h38, 32'h7, 2'b10);
    m_ovf = 0; m_coll = 0; m_fp = 0;
  endtask

  // sprites hitting line tgt in index order, first LS kept, overflow on the next hit
  function automatic void model_select(input int tgt);
    sel_n = 0;
    for (int i = 0; i < NS; i++) begin
      int dy;
      dy = (tgt - int'(m_attr[i][19:10]) + 1024) % 1024;
      if (m_attr[i][26] && dy < SH) begin
        if (sel_n == LS) begin
          m_ovf = 1;
          break;
        end
        sel_spr[sel_n] = i;
        sel_row[sel_n] = m_bmp[i*SH + dy];
        sel_n++;
      end
    end
  endfunction

  function automatic void model_pixel(input int x, output bit on, output logic [5:0] rgb, output int cnt);
    on = 0; rgb = '0; cnt = 0;
    for (int k = 0; k < sel_n; k++) begin
      int sx, dx;
      sx = int'(m_attr[sel_spr[k]][9:0]);
      dx = (x - sx + 1024) % 1024;
      if (dx < SW && sel_row[k][SW-1-dx]) begin
        if (!on) begin
          on  = 1;
          rgb = m_attr[sel_spr[k]][25:20];
        end
        cnt++;
      end
    end
  endfunction

  // evaluation runs during the line before tgt
  task automatic eval_line(input int tgt);
    visible = 1'b0;
    pix_y = (tgt == 0) ? 10'(VL) : 10'(tgt - 1);
    hsync = 1'b0; tick();
    hsync = 1'b1;
    repeat (NS + 4) tick();
    hsync = 1'b0; tick();
    model_select(tgt);
  endtask

  task automatic sweep(input string nm, input int x0, input int x1);
    bit on; logic [5:0] rgb; int cnt;
    visible = 1'b1;
    for (int x = x0; x <= x1; x++) begin
      pix_x = 10'(x);
      tick();
      model_pixel(x, on, rgb, cnt);
      if (cnt >= 2) m_coll = 1;
      chk($sformatf("%s_x%0d", nm, x), {25'b0, sprite_pixel_on, sprite_rgb}, {25'b0, on, rgb});
    end
    visible = 1'b0;
  endtask

  task automatic probe(input string nm, input int x, input bit e_on, input logic [5:0] e_rgb);
    bit on; logic [5:0] rgb; int cnt;
    visible = 1'b1; pix_x = 10'(x);
    tick();
    model_pixel(x, on, rgb, cnt);
    if (cnt >= 2 && on) m_coll = 1;
    chk({nm, "_on"},  32'(sprite_pixel_on), 32'(e_on));
    chk({nm, "_rgb"}, 32'(sprite_rgb), 32'(e_rgb));
    visible = 1'b0;
  endtask

  task automatic chk_status(input string nm);
    logic [31:0] d, e;
    rd(6'h38, d);
    e = {29'b0, m_ovf, 1'b0, m_fp};
`ifdef SPRITE_COLLISION_EN
    e[1] = m_coll;
`endif
    chk(nm, d, e);
  endtask

  initial begin
    logic [31:0] d, e;
    model_clear();
    vt[0]  = '{6'h00, 2'b10, 32'hFFFF_FFFF, 32'h07FF_FFFF};
    vt[1]  = '{6'h00, 2'b00, 32'h0000_0012, 32'h07FF_FF12};
    vt[2]  = '{6'h00, 2'b01, 32'hABCD_5678, 32'h07FF_5678};
    vt[3]  = '{6'h04, 2'b10, 32'h1234_5678, 32'h0234_5678};
    vt[4]  = '{6'h20, 2'b10, 32'hFFFF_FFFF, 32'h0000_0000};
    vt[5]  = '{6'h2C, 2'b10, 32'h0000_0001, 32'h0000_0000};
    vt[6]  = '{6'h3C, 2'b10, 32'hFFFF_FFFF, 32'h0000_0001};
    vt[7]  = '{6'h3C, 2'b00, 32'h0000_0000, 32'h0000_0000};
    vt[8]  = '{6'h30, 2'b00, 32'h0000_0005, 32'h0000_0005};
    vt[9]  = '{6'h34, 2'b10, 32'h0000_00A5, 32'h0000_0000};
    vt[10] = '{6'h30, 2'b10, 32'h0000_0005, 32'h0000_0005};
    vt[11] = '{6'h34, 2'b11, 32'h0000_0000, 32'h0000_00A5};

    repeat (3) tick();
    reset = 1'b0;

    // reset state
    chk("rst_pix_on", 32'(sprite_pixel_on), 32'h0);
    chk("rst_rgb", 32'(sprite_rgb), 32'h0);
    chk("rst_irq", 32'(user_interrupt), 32'h0);
    chk("rst_ready", 32'(data_ready), 32'h1);
    rd(6'h38, d); chk("rst_status", d, 32'h0);
    rd(6'h1C, d); chk("rst_attr7", d, 32'h0);

    // register table
    for (int i = 0; i < 12; i++) begin
      if (vt[i].wn != 2'b11) bus_write(vt[i].addr, vt[i].wdat, vt[i].wn);
      rd(vt[i].addr, d);
      chk($sformatf("regtab_%0d", i), d, vt[i].rexp);
    end
    m_bmp[5] = 8'hA5;

    // single sprite placement and 1-clk latency
    disable_all();
    set_sprite(0, 100, 50, 6'h30, 1'b1);
    fill_rows(0, 8'hFF);
    eval_line(50);
    probe("s0_x99", 99, 1'b0, 6'h00);
    probe("s0_x100", 100, 1'b1, 6'h30);
    probe("s0_x107", 107, 1'b1, 6'h30);
    probe("s0_x108", 108, 1'b0, 6'h00);
    visible = 1'b1; pix_x = 10'd99; tick();
    pix_x = 10'd100; #1;
    chk("lat_before_edge", 32'(sprite_pixel_on), 32'h0);
    tick();
    chk("lat_after_edge", 32'(sprite_pixel_on), 32'h1);
    visible = 1'b0;
    sweep("s0", 95, 112);

    // priority between overlapping sprites
    disable_all();
    clear_status();
    set_sprite(2, 200, 10, 6'h0C, 1'b1);
    set_sprite(5, 200, 10, 6'h03, 1'b1);
    fill_rows(2, 8'hFF);
    fill_rows(5, 8'hFF);
    eval_line(10);
    probe("prio", 200, 1'b1, 6'h0C);
    sweep("prio", 196, 210);
    rd(6'h38, d);
`ifdef SPRITE_COLLISION_EN
    chk("prio_status", d, 32'h2);
`else
    chk("prio_status", d, 32'h0);
`endif
    clear_status();

    // overflow: five sprites on one line, four slots
    disable_all();
    for (int i = 0; i < 5; i++) begin
      set_sprite(i, 300 + 16*i, 20, i + 1, 1'b1);
      fill_rows(i, 8'hFF);
    end
    eval_line(20);
    probe("ovf_s3", 348, 1'b1, 6'h04);
    probe("ovf_s4", 364, 1'b0, 6'h00);
    sweep("ovf", 296, 372);
    rd(6'h38, d); chk("ovf_status", d, 32'h4);
    bus_write(6'h38, 32'h4, 2'b10);
    m_ovf = 0;
    rd(6'h38, d); chk("ovf_cleared", d, 32'h0);

    // frame wrap: line 0 is evaluated during line V_LAST
    disable_all();
    set_sprite(0, 100, VL, 6'h11, 1'b1);
    set_sprite(1, 120, 0, 6'h22, 1'b1);
    eval_line(0);
    probe("wrap_ylast", 100, 1'b0, 6'h00);
    probe("wrap_y0", 120, 1'b1, 6'h22);
    sweep("wrap", 96, 130);

    // bitmap pointer wrap
    bus_write(6'h30, 32'd63, 2'b10);
    bus_write(6'h34, 32'h11, 2'b10);
    bus_write(6'h34, 32'h22, 2'b10);
    m_bmp[63] = 8'h11; m_bmp[0] = 8'h22;
    rd(6'h30, d); chk("ptr_wrapped", d, 32'h1);
    bus_write(6'h30, 32'd63, 2'b10);
    rd(6'h34, d); chk("bmp_row63", d, 32'h11);
    rd(6'h34, d); chk("bmp_read_noinc", d, 32'h11);
    bus_write(6'h30, 32'd0, 2'b10);
    rd(6'h34, d); chk("bmp_row0", d, 32'h22);

    // frame interrupt, then set-beats-clear
    clear_status();
    bus_write(6'h3C, 32'h1, 2'b10);
    vsync = 1'b1; tick();
    chk("irq_set", 32'(user_interrupt), 32'h1);
    rd(6'h38, d); chk("irq_status", d, 32'h1);
    bus_write(6'h38, 32'h1, 2'b10);
    chk("irq_cleared", 32'(user_interrupt), 32'h0);
    vsync = 1'b0; tick();
    vsync = 1'b1;
    bus_write(6'h38, 32'h1, 2'b10);
    rd(6'h38, d); chk("set_wins", d, 32'h1);
    chk("set_wins_irq", 32'(user_interrupt), 32'h1);

    // reset in the middle of SCAN
    disable_all();
    set_sprite(0, 100, 50, 6'h30, 1'b1);
    fill_rows(0, 8'hFF);
    pix_y = 10'd49; hsync = 1'b0; tick();
    hsync = 1'b1; tick();
    tick();
    tick();
    visible = 1'b1; pix_x = 10'd100; tick();
    chk("midscan_pix_before", 32'(sprite_pixel_on), 32'h1);
    reset = 1'b1; tick();
    chk("midscan_rst_pix", 32'(sprite_pixel_on), 32'h0);
    chk("midscan_rst_rgb", 32'(sprite_rgb), 32'h0);
    chk("midscan_rst_irq", 32'(user_interrupt), 32'h0);
    reset = 1'b0; hsync = 1'b0; vsync = 1'b0;
    repeat (NS + 2) tick();
    chk("midscan_after_pix", 32'(sprite_pixel_on), 32'h0);
    visible = 1'b0;
    rd(6'h00, d); chk("midscan_attr0", d, 32'h0);
    rd(6'h38, d); chk("midscan_status", d, 32'h0);
    model_clear();

    // randomized lines against the reference model
    for (int it = 0; it < 25; it++) begin
      int tgt;
      tgt = int'($urandom_range(0, VL));
      bus_write(6'h30, 32'h0, 2'b10);
      for (int r = 0; r < NS*SH; r++) begin
        logic [7:0] v;
        v = 8'($urandom);
        bus_write(6'h34, {24'b0, v}, 2'b00);
        m_bmp[r] = v;
      end
      for (int i = 0; i < NS; i++)
        set_sprite(i, int'($urandom_range(0, 70)), (tgt + 1024 - int'($urandom_range(0, 9))) % 1024,
                   int'($urandom_range(0, 63)), ($urandom_range(0, 3) != 0));
      eval_line(tgt);
      sweep($sformatf("rnd%0d", it), 0, 80);
      chk_status($sformatf("rnd%0d_status", it));
      clear_status();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
